// File: rtl/pool_pingpong_buf.sv
// Two-bank ping-pong line buffer feeding a 2x2 pooling stage: one bank fills
// with a two-row stripe while the other is read at random addresses.
module pool_pingpong_buf #(
  parameter int DATA_W = 8,
  parameter int COLS = 16,
  localparam int DEPTH = 2 * COLS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_release,
  output logic [DATA_W-1:0] d_out,
  output logic              rd_bank_valid,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              rd_err,
  output logic [1:0]        bank_full,
  output logic [AW-1:0]     fill_idx
);

  localparam int LAST_I = DEPTH - 1;
  localparam logic [AW-1:0] LAST_IDX = LAST_I[AW-1:0];

  logic [DATA_W-1:0] mem [2][DEPTH];

  logic [1:0]    full_q, full_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          err_q, err_d;

  logic wr_fire, wr_last, rel_fire, rd_hit, addr_ok;

  // Addresses past the end of a bank only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    assign addr_ok = ({1'b0, rd_addr} < DEPTH_L);
  end

  // Write handshake: a pixel moves when wr_valid and wr_ready are both high on
  // a rising edge; wr_ready depends only on registered state, never on wr_valid.
  always_comb begin
    wr_fire  = wr_valid & ~full_q[wb_q] & ~flush;
    wr_last  = wr_fire & (idx_q == LAST_IDX);
    rel_fire = rd_release & full_q[rb_q] & ~flush;
    rd_hit   = rd_en & full_q[rb_q] & ~flush;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= '0;
      idx_q  <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      err_q  <= 1'b0;
      d_out  <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      err_q  <= err_d;
      if (rd_hit) d_out <= addr_ok ? mem[rb_q][rd_addr] : '0;
    end
  end

  // Next state. A release and a final write never target the same bank:
  // the write bank is empty and the released bank is full.
  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    err_d  = err_q;
    if (flush) begin
      full_d = '0;
      idx_d  = '0;
      wb_d   = 1'b0;
      rb_d   = 1'b0;
      err_d  = 1'b0;
    end else begin
      if (rel_fire) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
      if (wr_fire) begin
        if (wr_last) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
          idx_d        = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if ((rd_en | rd_release) & ~full_q[rb_q]) err_d = 1'b1;
      if (rd_hit & ~addr_ok) err_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    wr_ready      = ~full_q[wb_q];
    rd_bank_valid = full_q[rb_q];
    wr_bank       = wb_q;
    rd_bank       = rb_q;
    rd_err        = err_q;
    bank_full     = full_q;
    fill_idx      = idx_q;
  end

  // Pixel storage carries no reset; a bank is only readable once fully rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wb_q][idx_q] <= d_in;
  end

endmodule

// File: tb/tb_pool_pingpong_buf.sv
// Bench for pool_pingpong_buf: directed vectors, corner sequences and random
// traffic checked against a pixel-count model of the two banks.
module tb_pool_pingpong_buf;

  localparam int DW = 8;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush, wr_valid, rd_en, rd_release;
  logic [DW-1:0] d_in;
  logic [AW-1:0] rd_addr;
  logic wr_ready, rd_bank_valid, wr_bank, rd_bank, rd_err;
  logic [DW-1:0] d_out;
  logic [1:0] bank_full;
  logic [AW-1:0] fill_idx;

  // Second instance with a 34-word bank so out-of-range addresses exist.
  logic s_flush, s_wr_valid, s_rd_en, s_rd_release;
  logic [DW-1:0] s_d_in;
  logic [5:0] s_rd_addr;
  logic s_wr_ready, s_rd_bank_valid, s_wr_bank, s_rd_bank, s_rd_err;
  logic [DW-1:0] s_d_out;
  logic [1:0] s_bank_full;
  logic [5:0] s_fill_idx;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pool_pingpong_buf #(.DATA_W(DW), .COLS(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .d_in(d_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .d_out(d_out), .rd_bank_valid(rd_bank_valid), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .rd_err(rd_err), .bank_full(bank_full), .fill_idx(fill_idx)
  );

  pool_pingpong_buf #(.DATA_W(DW), .COLS(17)) dut_long (
    .clk(clk), .rst(rst), .flush(s_flush), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .d_in(s_d_in), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_release(s_rd_release),
    .d_out(s_d_out), .rd_bank_valid(s_rd_bank_valid), .wr_bank(s_wr_bank),
    .rd_bank(s_rd_bank), .rd_err(s_rd_err), .bank_full(s_bank_full), .fill_idx(s_fill_idx)
  );

  // Model: pixels accepted and banks released since the last clear.
  int wr_cnt, rel_cnt;
  logic [DW-1:0] mm [2][DEPTH];
  logic [DW-1:0] dout_m;
  logic err_m;

  typedef struct {
    logic fl, wv;
    logic [DW-1:0] d;
    logic re;
    logic [AW-1:0] ra;
    logic rr;
    logic x_ready, x_valid, x_wb, x_rb;
    logic [DW-1:0] x_dout;
    logic x_err;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic reset_model();
    wr_cnt = 0;
    rel_cnt = 0;
    dout_m = '0;
    err_m = 1'b0;
  endtask

  task automatic compare_all();
    int f, rb;
    logic [1:0] xf;
    f = wr_cnt / DEPTH - rel_cnt;
    rb = rel_cnt % 2;
    xf = (f == 0) ? 2'b00 : (f == 1) ? ((rb == 1) ? 2'b10 : 2'b01) : 2'b11;
    check("m_wr_ready", wr_ready, (f < 2));
    check("m_rd_bank_valid", rd_bank_valid, (f > 0));
    check("m_wr_bank", wr_bank, (wr_cnt / DEPTH) % 2);
    check("m_rd_bank", rd_bank, rb);
    check("m_fill_idx", fill_idx, wr_cnt % DEPTH);
    check("m_bank_full", bank_full, xf);
    check("m_d_out", d_out, dout_m);
    check("m_rd_err", rd_err, err_m);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic fl, input logic wv, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic rr);
    int f, wb, wi, rb;
    flush = fl; wr_valid = wv; d_in = d; rd_en = re; rd_addr = ra; rd_release = rr;
    f = wr_cnt / DEPTH - rel_cnt;
    wb = (wr_cnt / DEPTH) % 2;
    wi = wr_cnt % DEPTH;
    rb = rel_cnt % 2;
    @(posedge clk);
    #1;
    if (fl) begin
      wr_cnt = 0;
      rel_cnt = 0;
      err_m = 1'b0;
    end else begin
      if (re) begin
        if (f > 0) dout_m = mm[rb][ra];
        else err_m = 1'b1;
      end
      if (rr) begin
        if (f > 0) rel_cnt++;
        else err_m = 1'b1;
      end
      if (wv && f < 2) begin
        mm[wb][wi] = d;
        wr_cnt++;
      end
    end
    compare_all();
  endtask

  task automatic idle_inputs();
    flush = 0; wr_valid = 0; d_in = '0; rd_en = 0; rd_addr = '0; rd_release = 0;
  endtask

  task automatic s_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    s_flush = 0; s_wr_valid = 0; s_d_in = '0; s_rd_en = 0; s_rd_addr = '0; s_rd_release = 0;
    reset_model();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_bank_valid", rd_bank_valid, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_d_out", d_out, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_fill_idx", fill_idx, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // fl wv d re ra rr | ready valid wb rb dout err
    vecs[0] = '{1'b0, 1'b0, 8'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'd9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      cycle(vecs[k].fl, vecs[k].wv, vecs[k].d, vecs[k].re, vecs[k].ra, vecs[k].rr);
      check($sformatf("vec%0d_ready", k), wr_ready, vecs[k].x_ready);
      check($sformatf("vec%0d_valid", k), rd_bank_valid, vecs[k].x_valid);
      check($sformatf("vec%0d_wr_bank", k), wr_bank, vecs[k].x_wb);
      check($sformatf("vec%0d_rd_bank", k), rd_bank, vecs[k].x_rb);
      check($sformatf("vec%0d_d_out", k), d_out, vecs[k].x_dout);
      check($sformatf("vec%0d_rd_err", k), rd_err, vecs[k].x_err);
    end
    check("vec_flush_idx", fill_idx, 0);

    // Fill bank 0 with 0..31 and read it back.
    for (int i = 0; i < 32; i++) cycle(0, 1, 8'(i), 0, '0, 0);
    check("fill_wr_bank", wr_bank, 1);
    check("fill_valid", rd_bank_valid, 1);
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, '0, 1, 5'(i), 0);
      check($sformatf("fill_rd%0d", i), d_out, i);
    end

    // Backpressure: second bank fills, 65th pixel dropped, release unblocks.
    for (int i = 0; i < 32; i++) cycle(0, 1, 8'(100 + i), 0, '0, 0);
    check("bp_ready_low", wr_ready, 0);
    cycle(0, 1, 8'hEE, 0, '0, 0);
    check("bp_drop_idx", fill_idx, 0);
    check("bp_drop_full", bank_full, 2'b11);
    cycle(0, 1, 8'hEE, 0, '0, 1);
    check("bp_rel_ready", wr_ready, 1);
    check("bp_rel_idx", fill_idx, 0);
    check("bp_rel_rd_bank", rd_bank, 1);
    cycle(0, 1, 8'h55, 0, '0, 0);
    check("bp_next_idx", fill_idx, 1);
    check("bp_next_wr_bank", wr_bank, 0);
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, '0, 1, 5'(i), 0);
      check($sformatf("bp_bank1_rd%0d", i), d_out, 100 + i);
    end

    // Errors on an empty buffer.
    cycle(0, 0, '0, 0, '0, 1);
    check("err_empty_valid", rd_bank_valid, 0);
    cycle(0, 0, '0, 1, 5'd2, 0);
    check("err_rd_empty", rd_err, 1);
    check("err_rd_dout_hold", d_out, 131);
    cycle(0, 0, '0, 0, '0, 1);
    check("err_rel_rd_bank", rd_bank, 0);
    check("err_rel_full", bank_full, 2'b00);

    // Final write of bank 1 coinciding with release of bank 0.
    for (int i = 1; i < 32; i++) cycle(0, 1, 8'(i), 0, '0, 0);
    for (int i = 0; i < 31; i++) cycle(0, 1, 8'(3 * i + 1), 0, '0, 0);
    cycle(0, 1, 8'(94), 0, '0, 1);
    check("sim_full", bank_full, 2'b10);
    check("sim_rd_bank", rd_bank, 1);
    check("sim_valid", rd_bank_valid, 1);
    cycle(0, 0, '0, 1, 5'd0, 0);
    check("sim_rd0", d_out, 1);
    cycle(0, 0, '0, 1, 5'd7, 0);
    check("sim_rd7", d_out, 22);
    cycle(0, 0, '0, 1, 5'd31, 0);
    check("sim_rd31", d_out, 94);

    // Flush on the final write of bank 0.
    for (int i = 0; i < 31; i++) cycle(0, 1, 8'(i + 50), 0, '0, 0);
    cycle(1, 1, 8'hAA, 0, '0, 0);
    check("flush_full", bank_full, 2'b00);
    check("flush_idx", fill_idx, 0);
    check("flush_wr_bank", wr_bank, 0);
    check("flush_rd_bank", rd_bank, 0);
    check("flush_err", rd_err, 0);
    check("flush_dout_hold", d_out, 94);

    // Asynchronous reset mid-fill at index 17.
    for (int i = 0; i < 32; i++) cycle(0, 1, 8'(i + 1), 0, '0, 0);
    cycle(0, 0, '0, 1, 5'd4, 0);
    check("prerst_dout", d_out, 5);
    for (int i = 0; i < 17; i++) cycle(0, 1, 8'(i + 200), 0, '0, 0);
    check("prerst_idx", fill_idx, 17);
    idle_inputs();
    #3 rst = 1'b0;
    #1;
    check("arst_idx", fill_idx, 0);
    check("arst_ready", wr_ready, 1);
    check("arst_dout", d_out, 0);
    check("arst_valid", rd_bank_valid, 0);
    check("arst_full", bank_full, 0);
    reset_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cycle(0, 1, 8'h3C, 0, '0, 0);
    check("post_rst_idx", fill_idx, 1);
    check("post_rst_wr_bank", wr_bank, 0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 7) == 0));
    end
    idle_inputs();

    // Out-of-range read on a 34-word bank.
    for (int i = 0; i < 34; i++) begin
      s_wr_valid = 1; s_d_in = 8'(i);
      s_step();
    end
    s_wr_valid = 0;
    check("long_valid", s_rd_bank_valid, 1);
    s_rd_en = 1; s_rd_addr = 6'd33;
    s_step();
    check("long_rd33", s_d_out, 33);
    check("long_rd33_err", s_rd_err, 0);
    s_rd_addr = 6'd40;
    s_step();
    check("long_rd40_dout", s_d_out, 0);
    check("long_rd40_err", s_rd_err, 1);
    s_rd_en = 0;
    s_step();
    check("long_err_sticky", s_rd_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
